rf_wb_arbiter: RTL
==================

# rf_wb_arbiter

Write-back arbiter for the 32x32 register file's single write port. It accepts write requests from NREQ independent write-back sources (ALU, load unit, multiply/divide unit) over valid/ready handshakes and grants one per cycle in round-robin order. It drives the register file's reg_wr/w_addr/write_data from registers updated on posedge CLK, so they are stable when the register file samples on negedge CLK. It also suppresses writes to $zero and counts arbitration stall cycles.

## Interface
- NREQ, 3: number of write-back requesters (2..8).
- DW, 32: data width.
- AW, 5: register address width.

- CLK  in  1  clock; arbitration and output registers on posedge.
- RESET  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester write request.
- req_addr  in  NREQ*AW  packed destination addresses; requester i occupies bits [i*AW +: AW].
- req_data  in  NREQ*DW  packed write data; requester i occupies bits [i*DW +: DW].
- req_ready  out  NREQ  one-hot grant, combinational in the same cycle.
- hold  in  1  pipeline stall; blocks all grants while high.
- reg_wr  out  1  register-file write enable (registered).
- w_addr  out  AW  register-file write address (registered).
- write_data  out  DW  register-file write data (registered).
- grant_id  out  3  index of the requester that produced the current reg_wr/w_addr/write_data (registered).
- wait_cnt  out  16  saturating count of cycles in which a valid requester was not granted.

## Operation
- Round-robin pointer `last` (3 bits) holds the index of the most recent grantee. Reset value is NREQ-1, so requester 0 has top priority after reset.
- Search order each cycle: last+1, last+2, …, wrapping modulo NREQ and ending at last itself. The first requester with req_valid=1 is granted.
- req_ready is all zeros when hold=1 or when no req_valid is high. Otherwise exactly one bit of req_ready is set.
- A transfer occurs for requester i when req_valid[i] && req_ready[i] is high at posedge. Requesters hold valid, addr and data stable until that transfer. Dropping valid before the transfer is legal and withdraws the request.
- On transfer, at the same posedge:
  - `last` <= i.
  - w_addr <= addr_i, write_data <= data_i, grant_id <= i.
  - reg_wr <= (addr_i != 0). A write to $zero is accepted (ready returned) but never reaches the register file.
- Cycle without a transfer: reg_wr <= 0. w_addr, write_data and grant_id hold their values.
- wait_cnt increments by 1 at posedge when (req_valid & ~req_ready) != 0, which includes all cycles with hold=1 and a valid pending. It saturates at 16'hFFFF and does not wrap. It is cleared only by RESET.
- Simultaneous requests to the same address are written in grant order. The last grantee's data persists. No merging.
- Starvation bound: a continuously valid requester is granted within NREQ non-hold cycles.

## Timing
- Asynchronous RESET values: reg_wr=0, w_addr=0, write_data=0, grant_id=0, wait_cnt=0, last=NREQ-1.
- While RESET is high, req_ready=0.
- Reset mid-operation: a write that is registered but not yet committed (reg_wr=1 before the negedge) is discarded. Requesters must re-present it.
- Latency for a transfer at posedge k:
  - reg_wr/w_addr/write_data are valid from k until posedge k+1.
  - The register file commits at the negedge between k and k+1.
  - Data is readable by a read registered at posedge k+1.
- Throughput: one write per cycle. Back-to-back grants produce reg_wr=1 on consecutive cycles with no bubble.
- hold takes effect combinationally in the same cycle. The cycle after a hold-only cycle has reg_wr=0.
- req_ready depends combinationally on req_valid, hold, RESET and `last`. There is no combinational path from req_addr/req_data to req_ready.

## Test plan
- Reset: assert RESET mid-simulation with req_valid=3'b111 → all outputs 0 and req_ready=0 immediately. After release, the first grant goes to requester 0.
- Single requester: req1 writes addr 7, data 0x1234_5678 at posedge k → reg_wr=1, w_addr=7, write_data=0x12345678, grant_id=1 during cycle k. A read of reg 7 registered at posedge k+1 returns 0x12345678.
- Round-robin: all three valid continuously for 6 cycles → grant order 0,1,2,0,1,2, reg_wr=1 every cycle, wait_cnt increments by 1 each cycle.
- $zero suppression: req0 writes addr 0, data 0xFFFF_FFFF → req_ready[0]=1, reg_wr=0, grant_id=0, and register 0 remains 0.
- Hold: req2 valid with hold=1 for 4 cycles → req_ready=0 and wait_cnt=4. hold drops → req2 granted that cycle, reg_wr=1 the next cycle.
- Saturation and same-address ordering: preload wait_cnt near the limit by 70000 stalled cycles → wait_cnt=0xFFFF, no wrap. req0 and req1 both write addr 5 with 0xA and 0xB → final reg 5 = 0xB (grant order 0 then 1).

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the register file's single write port: round-robin
// grant of NREQ sources, registered write outputs, $zero suppression, stall count.
module rf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               hold,
  output logic               reg_wr,
  output logic [AW-1:0]      w_addr,
  output logic [DW-1:0]      write_data,
  output logic [2:0]         grant_id,
  output logic [15:0]        wait_cnt
);

  logic [2:0]      last;
  logic [NREQ-1:0] grant;
  logic [2:0]      sel;
  logic            found;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            xfer;

  // Two passes: indices above `last` first, then wrap around to 0..last.
  always_comb begin
    grant = '0;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && (i > int'(last)) && req_valid[i]) begin
        grant[i] = 1'b1;
        sel      = 3'(i);
        found    = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && (i <= int'(last)) && req_valid[i]) begin
        grant[i] = 1'b1;
        sel      = 3'(i);
        found    = 1'b1;
      end
    end
  end

  assign req_ready = (RESET || hold) ? '0 : grant;
  assign xfer      = |req_ready;

  // Address/data mux is driven by the grant only, never back into req_ready.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      last       <= 3'(NREQ-1);
      reg_wr     <= 1'b0;
      w_addr     <= '0;
      write_data <= '0;
      grant_id   <= '0;
      wait_cnt   <= '0;
    end else begin
      if (xfer) begin
        last       <= sel;
        w_addr     <= sel_addr;
        write_data <= sel_data;
        grant_id   <= sel;
        reg_wr     <= (sel_addr != '0);
      end else begin
        reg_wr <= 1'b0;
      end
      if ((|(req_valid & ~req_ready)) && (wait_cnt != 16'hFFFF))
        wait_cnt <= wait_cnt + 16'd1;
    end
  end

endmodule
